// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings, FSM state type and lane helpers for dmem_bridge
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  function automatic logic [3:0] be_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: be_mask = 4'b0001 << lane;
      SZ_HALF: be_mask = 4'b0011 << lane;
      default: be_mask = 4'b1111;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then extend; word loads pass through.
  function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sgn);
    logic [31:0] sh;
    sh = rdata >> {lane, 3'b000};
    case (size)
      SZ_BYTE: load_extract = {{24{sgn & sh[7]}}, sh[7:0]};
      SZ_HALF: load_extract = {{16{sgn & sh[15]}}, sh[15:0]};
      default: load_extract = rdata;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// rtl/dmem_lane_unit.sv - combinational store steering, byte enables and load extract/extend
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_sgn,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  always_comb begin
    o_wdata = i_wdata;
    case (i_size)
      SZ_BYTE: o_wdata = {4{i_wdata[7:0]}};
      SZ_HALF: o_wdata = {2{i_wdata[15:0]}};
      default: o_wdata = i_wdata;
    endcase
  end

  assign o_be    = be_mask(i_size, i_lane);
  assign o_rdata = load_extract(i_rdata, i_size, i_lane, i_sgn);

endmodule

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - CPU data port to synchronous-read DMEM bridge with sized access and faults
// Optional counters stat_loads/stat_stores/stat_faults are built when DMEM_STATS_EN is defined.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter logic [31:0] DM_BASE    = 32'h1001_0000,
  parameter int          DEPTH_LOG2 = 11,
  parameter int          RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [1:0]            cpu_size,
  input  logic                  cpu_signed,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_done,
  output logic                  cpu_fault,
  output logic                  cpu_busy,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]           stat_loads,
  output logic [31:0]           stat_stores,
  output logic [31:0]           stat_faults
`endif
);

  localparam logic [32:0] RANGE_BYTES = 33'd4 << DEPTH_LOG2;
  localparam logic [2:0]  LAT_M1      = 3'(RD_LAT - 1);

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_sgn;
  logic [1:0]  r_lane;
  logic        r_fault;

  logic [31:0] w_off;
  logic        w_fault;
  logic        w_idle;
  logic [1:0]  w_size;
  logic [1:0]  w_lane;
  logic        w_sgn;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_rdata_ext;

  assign w_off   = cpu_addr - DM_BASE;
  assign w_fault = (cpu_size == 2'b11)
                 || (cpu_size == SZ_HALF && cpu_addr[0])
                 || (cpu_size == SZ_WORD && cpu_addr[1:0] != 2'b00)
                 || ({1'b0, w_off} >= RANGE_BYTES);

  // Steering sees live CPU fields while accepting, latched fields afterwards.
  assign w_idle = (r_state == IDLE);
  assign w_size = w_idle ? cpu_size   : r_size;
  assign w_lane = w_idle ? w_off[1:0] : r_lane;
  assign w_sgn  = w_idle ? cpu_signed : r_sgn;

  dmem_lane_unit u_lane (
    .i_size  (w_size),
    .i_lane  (w_lane),
    .i_sgn   (w_sgn),
    .i_wdata (cpu_wdata),
    .i_rdata (mem_rdata),
    .o_be    (w_be),
    .o_wdata (w_wdata_rep),
    .o_rdata (w_rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 3'd0;
      r_we      <= 1'b0;
      r_size    <= SZ_BYTE;
      r_sgn     <= 1'b0;
      r_lane    <= 2'b00;
      r_fault   <= 1'b0;
      cpu_rdata <= 32'd0;
      cpu_done  <= 1'b0;
      cpu_fault <= 1'b0;
      cpu_busy  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
`ifdef DMEM_STATS_EN
      stat_loads  <= 32'd0;
      stat_stores <= 32'd0;
      stat_faults <= 32'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu_req) begin
            r_we     <= cpu_we;
            r_size   <= cpu_size;
            r_sgn    <= cpu_signed;
            r_lane   <= w_off[1:0];
            r_fault  <= w_fault;
            cpu_busy <= 1'b1;
            if (w_fault) begin
              r_state   <= RESP;
              cpu_done  <= 1'b1;
              cpu_fault <= 1'b1;
              cpu_rdata <= 32'd0;
            end else begin
              r_state  <= ISSUE;
              mem_en   <= 1'b1;
              mem_addr <= w_off[DEPTH_LOG2+1:2];
              mem_we   <= cpu_we ? w_be : 4'b0000;
              if (cpu_we) begin
                mem_wdata <= w_wdata_rep;
              end
            end
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 4'b0000;
          if (r_we) begin
            r_state   <= RESP;
            cpu_done  <= 1'b1;
            cpu_rdata <= 32'd0;
          end else begin
            r_state <= WAIT;
            r_cnt   <= LAT_M1;
          end
        end
        WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state   <= RESP;
            cpu_done  <= 1'b1;
            cpu_rdata <= w_rdata_ext;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        RESP: begin
          r_state   <= IDLE;
          cpu_done  <= 1'b0;
          cpu_fault <= 1'b0;
          cpu_busy  <= 1'b0;
`ifdef DMEM_STATS_EN
          if (r_fault) begin
            stat_faults <= stat_faults + 32'd1;
          end else if (r_we) begin
            stat_stores <= stat_stores + 32'd1;
          end else begin
            stat_loads <= stat_loads + 32'd1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - randomized check of dmem_bridge (RD_LAT 1 and 3) against a byte-array model
module tb_dmem_bridge;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int          DL2  = 11;
  localparam int          NW   = 1 << DL2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic        cpu_signed = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;

  logic [31:0]    rdata_w [2];
  logic           done_w  [2];
  logic           fault_w [2];
  logic           busy_w  [2];
  logic           en_w    [2];
  logic [3:0]     we_w    [2];
  logic [DL2-1:0] addr_w  [2];
  logic [31:0]    wd_w    [2];
  logic [31:0]    mrd     [2];
`ifdef DMEM_STATS_EN
  logic [31:0] st_ld [2];
  logic [31:0] st_st [2];
  logic [31:0] st_ft [2];
  int e_loads = 0, e_stores = 0, e_faults = 0;
`endif

  logic [31:0] ram  [2][NW];
  logic [31:0] pipe [2][3];
  logic        ram_ready = 1'b0;
  logic [7:0]  refb [4*NW];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_bridge #(.DM_BASE(BASE), .DEPTH_LOG2(DL2), .RD_LAT(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_signed(cpu_signed), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(rdata_w[0]), .cpu_done(done_w[0]), .cpu_fault(fault_w[0]), .cpu_busy(busy_w[0]),
    .mem_en(en_w[0]), .mem_we(we_w[0]), .mem_addr(addr_w[0]), .mem_wdata(wd_w[0]),
    .mem_rdata(mrd[0])
`ifdef DMEM_STATS_EN
    , .stat_loads(st_ld[0]), .stat_stores(st_st[0]), .stat_faults(st_ft[0])
`endif
  );

  dmem_bridge #(.DM_BASE(BASE), .DEPTH_LOG2(DL2), .RD_LAT(3)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_signed(cpu_signed), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(rdata_w[1]), .cpu_done(done_w[1]), .cpu_fault(fault_w[1]), .cpu_busy(busy_w[1]),
    .mem_en(en_w[1]), .mem_we(we_w[1]), .mem_addr(addr_w[1]), .mem_wdata(wd_w[1]),
    .mem_rdata(mrd[1])
`ifdef DMEM_STATS_EN
    , .stat_loads(st_ld[1]), .stat_stores(st_st[1]), .stat_faults(st_ft[1])
`endif
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'hA5C3_0F17;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Synchronous-read RAM for each DUT; read data appears RD_LAT edges after mem_en.
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < NW; i++) begin
        ram[0][i] <= init_word(i);
        ram[1][i] <= init_word(i);
      end
      ram_ready <= 1'b1;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (en_w[d]) begin
          if (we_w[d] == 4'b0000) pipe[d][0] <= ram[d][addr_w[d]];
          for (int b = 0; b < 4; b++)
            if (we_w[d][b]) ram[d][addr_w[d]][8*b +: 8] <= wd_w[d][8*b +: 8];
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      pipe[d][1] <= pipe[d][0];
      pipe[d][2] <= pipe[d][1];
    end
  end

  assign mrd[0] = pipe[0][0];
  assign mrd[1] = pipe[1][2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic run_access(input logic we, input logic [1:0] sz, input logic sg,
                            input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] off, exp_rd, exp_wd;
    logic [3:0]  exp_be;
    logic        flt;
    int          nb, lane;
    int          done_at [2];
    int          ndone [2];
    int          nen [2];
    logic [31:0] got_rd [2];
    logic        got_flt [2];

    off  = addr - BASE;
    flt  = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0)
        || (off >= 32'(4 * NW));
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lane = int'(off % 4);
    exp_be = 4'(((1 << nb) - 1) << lane);
    exp_wd = (nb == 1) ? {4{wd[7:0]}} : (nb == 2) ? {2{wd[15:0]}} : wd;
    exp_rd = 32'd0;
    if (!flt && !we) begin
      for (int i = 0; i < nb; i++) exp_rd = exp_rd | (32'(refb[off + 32'(i)]) << (8 * i));
      if (sg && nb < 4 && exp_rd[8*nb-1]) exp_rd = exp_rd | ~((32'd1 << (8 * nb)) - 32'd1);
    end

    @(negedge clk);
    cpu_we = we; cpu_size = sz; cpu_signed = sg; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      done_at[d] = 0; ndone[d] = 0; nen[d] = 0; got_rd[d] = 32'd0; got_flt[d] = 1'b0;
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) cpu_req = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (en_w[d]) begin
          nen[d]++;
          check("issue_addr", 32'(addr_w[d]), 32'(off[DL2+1:2]));
          check("issue_be", 32'(we_w[d]), we ? 32'(exp_be) : 32'd0);
          if (we) check("issue_wdata", wd_w[d], exp_wd);
        end
        if (done_w[d]) begin
          ndone[d]++;
          done_at[d] = k;
          got_rd[d] = rdata_w[d];
          got_flt[d] = fault_w[d];
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      check("done_cycle", 32'(done_at[d]), flt ? 32'd1 : we ? 32'd2 : 32'(2 + lat_of(d)));
      check("done_count", 32'(ndone[d]), 32'd1);
      check("fault", 32'(got_flt[d]), 32'(flt));
      check("rdata", got_rd[d], exp_rd);
      check("rdata_hold", rdata_w[d], exp_rd);
      check("mem_en_count", 32'(nen[d]), flt ? 32'd0 : 32'd1);
    end

    if (!flt && we)
      for (int i = 0; i < nb; i++) refb[off + 32'(i)] = wd[8*i +: 8];
`ifdef DMEM_STATS_EN
    if (flt) e_faults++;
    else if (we) e_stores++;
    else e_loads++;
`endif
  endtask

  initial begin
    logic [31:0] en_mask [2];
    logic [31:0] done_mask [2];
    logic [31:0] busy_mask [2];
    int          nd;

    for (int i = 0; i < NW; i++)
      for (int j = 0; j < 4; j++) refb[4*i+j] = init_word(i) >> (8 * j);

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_rdata", rdata_w[d], 32'd0);
      check("rst_flags", {28'd0, done_w[d], fault_w[d], busy_w[d], en_w[d]}, 32'd0);
      check("rst_mem_we", 32'(we_w[d]), 32'd0);
      check("rst_mem_addr", 32'(addr_w[d]), 32'd0);
      check("rst_mem_wdata", wd_w[d], 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run_access(1'b1, 2'd2, 1'b0, 32'h1001_0008, 32'hDEAD_BEEF);
    run_access(1'b0, 2'd2, 1'b0, 32'h1001_0008, 32'd0);
    run_access(1'b1, 2'd2, 1'b0, 32'h1001_0008, 32'h80FF_7F01);
    run_access(1'b0, 2'd0, 1'b1, 32'h1001_000B, 32'd0);
    run_access(1'b0, 2'd0, 1'b0, 32'h1001_000B, 32'd0);
    run_access(1'b0, 2'd1, 1'b1, 32'h1001_000A, 32'd0);
    run_access(1'b1, 2'd1, 1'b0, 32'h1001_0006, 32'h1234_ABCD);
    run_access(1'b0, 2'd2, 1'b0, 32'h1001_0004, 32'd0);
    run_access(1'b0, 2'd2, 1'b0, 32'h1001_0002, 32'd0);
    run_access(1'b1, 2'd1, 1'b0, 32'h1001_0001, 32'h5555_5555);
    run_access(1'b0, 2'd2, 1'b0, 32'h1000_FFFC, 32'd0);
    run_access(1'b1, 2'd2, 1'b0, 32'h1001_2000, 32'h1111_1111);
    run_access(1'b0, 2'd3, 1'b0, 32'h1001_0010, 32'd0);
    run_access(1'b0, 2'd2, 1'b0, 32'h1001_1FFC, 32'd0);

    // Request held high across RESP: second store accepted in the first IDLE cycle.
    @(negedge clk);
    cpu_we = 1'b1; cpu_size = 2'd2; cpu_signed = 1'b0; cpu_addr = 32'h1001_0020;
    cpu_wdata = 32'hCAFE_F00D; cpu_req = 1'b1;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin en_mask[d] = 0; done_mask[d] = 0; busy_mask[d] = 0; end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 4) cpu_req = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (en_w[d])   en_mask[d][k] = 1'b1;
        if (done_w[d]) done_mask[d][k] = 1'b1;
        if (busy_w[d]) busy_mask[d][k] = 1'b1;
      end
    end
    for (int d = 0; d < 2; d++) begin
      check("b2b_mem_en", en_mask[d], 32'h0000_0012);
      check("b2b_done", done_mask[d], 32'h0000_0024);
      check("b2b_busy", busy_mask[d], 32'h0000_0036);
    end
    for (int i = 0; i < 4; i++) refb[32'h20 + 32'(i)] = 8'(32'hCAFE_F00D >> (8 * i));
`ifdef DMEM_STATS_EN
    e_stores += 2;
`endif

    // Reset while both DUTs sit in WAIT.
    @(negedge clk);
    cpu_we = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h1001_0020; cpu_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("midrst_flags", {28'd0, done_w[d], fault_w[d], busy_w[d], en_w[d]}, 32'd0);
      check("midrst_mem_we", 32'(we_w[d]), 32'd0);
    end
    rst_n = 1'b1;
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (done_w[d] || busy_w[d]) nd++;
    end
    check("midrst_no_done", 32'(nd), 32'd0);

`ifdef DMEM_STATS_EN
    e_loads = 0; e_stores = 0; e_faults = 0;
    run_access(1'b0, 2'd0, 1'b1, 32'h1001_0021, 32'd0);
    run_access(1'b1, 2'd1, 1'b0, 32'h1001_0030, 32'h0000_BEEF);
    run_access(1'b0, 2'd1, 1'b0, 32'h1001_0030, 32'd0);
    run_access(1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'd0);
    for (int d = 0; d < 2; d++) begin
      check("stat_loads_211", st_ld[d], 32'd2);
      check("stat_stores_211", st_st[d], 32'd1);
      check("stat_faults_211", st_ft[d], 32'd1);
    end
`endif

    for (int n = 0; n < 120; n++) begin
      logic [1:0]  sz;
      logic [31:0] off, addr;
      int          r;
      r   = $urandom_range(0, 19);
      sz  = (r == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      off = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4 * NW - 1))
                                        : 32'($urandom_range(0, 63));
      if (sz == 2'd1 && $urandom_range(0, 3) != 0) off[0] = 1'b0;
      if (sz == 2'd2 && $urandom_range(0, 3) != 0) off[1:0] = 2'b00;
      addr = BASE + off;
      if (r == 1) addr = BASE + 32'(4 * NW) + 32'($urandom_range(0, 64));
      if (r == 2) addr = BASE - 32'd1 - 32'($urandom_range(0, 64));
      run_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom);
    end

`ifdef DMEM_STATS_EN
    for (int d = 0; d < 2; d++) begin
      check("stat_loads", st_ld[d], 32'(e_loads));
      check("stat_stores", st_st[d], 32'(e_stores));
      check("stat_faults", st_ft[d], 32'(e_faults));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Parametrised data-memory bridge between the single-cycle CPU's data port and a synchronous-read DMEM macro. Successor to the fixed "subtract 0x10010000, divide by 4" address path.
- Adds byte and halfword access with lane steering and byte enables, sign/zero extension, a range and alignment fault check, and a req/done handshake that tolerates a RAM read latency.
- Sits between the cpu data port and DMEM at the top-level dataflow module.

Parameters:
- DM_BASE, 32'h1001_0000, byte address mapped to DMEM word 0.
- DEPTH_LOG2, 11, log2 of DMEM depth in 32-bit words; mem_addr width.
- RD_LAT, 1, cycles from the mem_en issue edge to mem_rdata valid; legal range 1..7.

Ports:
- clk  in  1  bridge clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- cpu_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  store data, right-justified.
- cpu_rdata  out  32  load result; valid while cpu_done=1, held until the next done.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_fault  out  1  qualifies cpu_done; access rejected.
- cpu_busy  out  1  high in any state other than IDLE.
- mem_en  out  1  RAM enable, one-cycle pulse per access.
- mem_we  out  4  byte write enables; bit i = byte lane i.
- mem_addr  out  DEPTH_LOG2  RAM word index.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  RAM read data.

Behaviour:
- Clock and reset: one clock, clk; reset synchronous active-low, rst_n. State and counters change only on the rising edge of clk.
- Reset values: state=IDLE. cpu_rdata, cpu_done, cpu_fault, cpu_busy, mem_en, mem_we, mem_addr, mem_wdata all 0.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If cpu_req=1, latch we, size, signed, addr and wdata, compute the fault bit, and go to ISSUE; go to RESP instead if faulted.
- Fault rules (fault = any of):
  - cpu_size=11.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Range miss: off = addr − DM_BASE (32-bit unsigned, wraps) and off ≥ 4·2^DEPTH_LOG2. Addresses below DM_BASE therefore fault.
  - A faulted access never asserts mem_en.
- Address and lanes:
  - mem_addr = off[DEPTH_LOG2+1:2]; lane = off[1:0].
- ISSUE (one cycle): mem_en=1.
  - Store:
    - mem_we is 0001<<lane for a byte, 0011<<lane for a half, 1111 for a word.
    - mem_wdata is {4{wdata[7:0]}} for a byte, {2{wdata[15:0]}} for a half, wdata for a word.
    - Next state is RESP.
  - Load: mem_we=0000; next state is WAIT.
- WAIT:
  - Lasts exactly RD_LAT cycles, counted by a 3-bit down-counter.
  - mem_rdata is sampled at the end of the last WAIT cycle.
  - The selected byte or half is extracted by lane, then extended per cpu_signed. Word loads ignore cpu_signed.
- RESP (one cycle):
  - cpu_done=1 and cpu_fault = latched fault.
  - cpu_rdata = extracted value for a good load, 0 for a store or fault.
  - Next state is IDLE.
- mem_en and mem_we are 0 outside ISSUE. mem_addr and mem_wdata hold their last values.
- Latency from the accept edge (cycle T) to cpu_done:
  - Store done at T+2.
  - Load done at T+2+RD_LAT.
  - Fault done at T+1.
- Back-to-back operation: cpu_req is ignored outside IDLE. The next request is accepted no earlier than the cycle after RESP. The CPU must hold its request fields until it sees cpu_done.
- Reset mid-operation: the next edge forces IDLE and drops mem_en and mem_we. No done is issued, and any store not yet issued is discarded.

Optional Feature:
- Macro DMEM_STATS_EN.
- Defined:
  - Adds outputs stat_loads, stat_stores and stat_faults, each 32-bit, reset to 0.
  - Each counter increments by 1 in RESP for a good load, a good store or a fault respectively, and wraps at 2^32.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package dmem_pkg holds:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - The state enum.
  - Helper functions be_mask(size, lane) and load_extract(rdata, size, lane, signed).
- One sub-module, dmem_lane_unit, is combinational: store steering, byte enables and load extract/extend. The FSM stays in dmem_bridge.

Test Plan:
- Word store: addr 0x1001_0008, wdata 0xDEAD_BEEF → ISSUE with mem_addr=2, mem_we=1111, mem_wdata=0xDEADBEEF; done at T+2, fault=0.
- Signed byte load:
  - Setup: RAM word 2 = 0x80FF_7F01.
  - Stimulus: byte load at 0x1001_000B with signed=1.
  - Response: cpu_rdata=0xFFFF_FF80 at T+3 (RD_LAT=1).
  - Same load with signed=0: 0x0000_0080.
- Half store at 0x1001_0006, wdata 0x1234_ABCD → mem_addr=1, mem_we=1100, mem_wdata=0xABCD_ABCD.
- Faults, each giving done=1, fault=1, rdata=0 at T+1 and no mem_en:
  - Word at 0x1001_0002.
  - Half at 0x1001_0001.
  - Address 0x1000_FFFC.
  - Address 0x1001_2000 (DEPTH_LOG2=11).
  - cpu_size=11.
- RD_LAT=3 load → done exactly at T+5. A cpu_req held high through RESP is accepted at the first IDLE cycle.
- rst_n=0 during WAIT → next cycle IDLE, done never pulses. With DMEM_STATS_EN: after 2 loads, 1 store and 1 fault, the counters read 2/1/1.
